mult_store: RTL and testbench

MULT_STORE -- requirements
Module: mult_store

---
 rtl/mult_store_if.sv | 36 +++
 rtl/mult_store.sv | 78 +++++++
 tb/tb_mult_store.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/mult_store_if.sv
// mult_store_if
//   Groups the datapath signals of mult_store into one bundle.
//   layer2In  : shared unsigned activation
//   weightsIn : packed two's-complement weights, neuron 0 at the LSBs
//   sumOut    : packed signed accumulators, neuron 0 at the LSBs
//   satOut    : sticky per-neuron saturation flags
//   Handshake: none. There is no valid/ready pair. The block samples
//   layer2In/weightsIn on every rising clk edge while clr is low, and
//   sumOut/satOut are always valid register outputs.
//   modport master : the side that drives activations and weights
//   modport slave  : mult_store itself
interface mult_store_if #(
  parameter int N_NEURONS = 10,
  parameter int IN_W      = 3,
  parameter int WT_W      = 3,
  parameter int OUT_W     = 8
);
  logic [IN_W-1:0]            layer2In;
  logic [N_NEURONS*WT_W-1:0]  weightsIn;
  logic [N_NEURONS*OUT_W-1:0] sumOut;
  logic [N_NEURONS-1:0]       satOut;

  modport master (
    output layer2In,
    output weightsIn,
    input  sumOut,
    input  satOut
  );

  modport slave (
    input  layer2In,
    input  weightsIn,
    output sumOut,
    output satOut
  );
endinterface

// File: rtl/mult_store.sv
// mult_store
//   N_NEURONS parallel multiply-accumulate lanes sharing one activation.
//   Each rising clk edge adds layer2In (unsigned) * w_k (signed) into a
//   signed OUT_W accumulator. The sum saturates instead of wrapping, and a
//   sticky flag records that a lane has clamped.
//   Ports:
//     clk : rising-edge clock
//     clr : asynchronous active-high clear of all accumulators and flags
//     bus : mult_store_if.slave (layer2In, weightsIn in; sumOut, satOut out)
module mult_store #(
  parameter int N_NEURONS = 10,
  parameter int IN_W      = 3,
  parameter int WT_W      = 3,
  parameter int OUT_W     = 8
) (
  input logic         clk,
  input logic         clr,
  mult_store_if.slave bus
);

  // Exact product width: unsigned IN_W times signed WT_W.
  localparam int PW = IN_W + WT_W + 1;
  // Adder width is wide enough that neither the accumulator nor the product
  // overflows before the clamp is applied.
  localparam int SW = ((OUT_W > PW) ? OUT_W : PW) + 1;

  localparam logic signed [SW-1:0] SAT_MAX = SW'((64'd1 << (OUT_W - 1)) - 64'd1);
  localparam logic signed [SW-1:0] SAT_MIN = ~SAT_MAX;

  for (genvar k = 0; k < N_NEURONS; k++) begin : g_lane
    logic [WT_W-1:0]         w_raw;
    logic signed [PW-1:0]    a_ext;
    logic signed [PW-1:0]    w_ext;
    logic signed [PW-1:0]    prod;
    logic signed [SW-1:0]    sum_wide;
    logic signed [OUT_W-1:0] acc_q;
    logic signed [OUT_W-1:0] acc_d;
    logic                    sat_q;
    logic                    clamp;

    assign w_raw = bus.weightsIn[k*WT_W +: WT_W];
    // The activation is zero-extended and the weight sign-extended to the
    // full product width, so the PW-bit signed multiply is exact.
    assign a_ext = $signed({{(PW - IN_W){1'b0}}, bus.layer2In});
    assign w_ext = $signed({{(PW - WT_W){w_raw[WT_W-1]}}, w_raw});
    assign prod  = a_ext * w_ext;

    assign sum_wide = $signed({{(SW - OUT_W){acc_q[OUT_W-1]}}, acc_q})
                    + $signed({{(SW - PW){prod[PW-1]}}, prod});

    always_comb begin
      acc_d = sum_wide[OUT_W-1:0];
      clamp = 1'b0;
      if (sum_wide > SAT_MAX) begin
        acc_d = SAT_MAX[OUT_W-1:0];
        clamp = 1'b1;
      end else if (sum_wide < SAT_MIN) begin
        acc_d = SAT_MIN[OUT_W-1:0];
        clamp = 1'b1;
      end
    end

    always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
        acc_q <= '0;
        sat_q <= 1'b0;
      end else begin
        acc_q <= acc_d;
        // The flag is sticky: only clr clears it.
        sat_q <= sat_q | clamp;
      end
    end

    assign bus.sumOut[k*OUT_W +: OUT_W] = acc_q;
    assign bus.satOut[k]                = sat_q;
  end

endmodule

// File: tb/tb_mult_store.sv
module tb_mult_store;
  localparam int N  = 10;
  localparam int NV = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic clr = 1'b1;
  always #5 clk = ~clk;

  mult_store_if #(.N_NEURONS(N), .IN_W(3), .WT_W(3), .OUT_W(8)) bus ();

  mult_store #(.N_NEURONS(N), .IN_W(3), .WT_W(3), .OUT_W(8)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  // ---------------- scoreboard ----------------
  int tests_run = 0;
  int tests_failed = 0;
  logic [N*8-1:0] exp_q[$];

  typedef struct {
    logic       do_rst;
    logic [2:0] in_val;
    logic [2:0] w_even;
    logic [2:0] w_odd;
    int         edges;
    logic [7:0] exp_even;
    logic [7:0] exp_odd;
    logic [N-1:0] exp_sat;
  } vec_t;

  vec_t vecs [NV];

  function automatic logic [N*3-1:0] pack_w(input logic [2:0] we, input logic [2:0] wo);
    logic [N*3-1:0] r;
    for (int k = 0; k < N; k++) r[k*3 +: 3] = (k % 2 == 0) ? we : wo;
    return r;
  endfunction

  function automatic logic [N*8-1:0] pack_s(input logic [7:0] se, input logic [7:0] so);
    logic [N*8-1:0] r;
    for (int k = 0; k < N; k++) r[k*8 +: 8] = (k % 2 == 0) ? se : so;
    return r;
  endfunction

  task automatic check_sum(input string name);
    logic [N*8-1:0] exp_v;
    exp_v = exp_q.pop_front();
    tests_run++;
    if (bus.sumOut !== exp_v) begin
      tests_failed++;
      $display("FAIL %s sumOut got %h expected %h", name, bus.sumOut, exp_v);
    end
  endtask

  task automatic check_sat(input string name, input logic [N-1:0] exp_v);
    tests_run++;
    if (bus.satOut !== exp_v) begin
      tests_failed++;
      $display("FAIL %s satOut got %h expected %h", name, bus.satOut, exp_v);
    end
  endtask

  // ---------------- driver tasks ----------------
  // All driving happens at the falling edge; sampling at the next falling edge.
  task automatic do_reset();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic run_edges(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  // Watchdog in case anything stalls the run.
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    // w=-1 on even lanes, +3 on odd lanes (the 30'b011_111_... pattern).
    vecs[0]  = '{1'b1, 3'd0, 3'b111, 3'b011, 1, 8'h00, 8'h00, 10'h000};
    vecs[1]  = '{1'b0, 3'd1, 3'b111, 3'b011, 1, 8'hFF, 8'h03, 10'h000};
    vecs[2]  = '{1'b0, 3'd2, 3'b111, 3'b011, 1, 8'hFD, 8'h09, 10'h000};
    // +21 per edge: 21, 42, then 126 after 6 edges, 127 clamp on 7th+1.
    vecs[3]  = '{1'b1, 3'd7, 3'b011, 3'b011, 1, 8'd21,  8'd21,  10'h000};
    vecs[4]  = '{1'b0, 3'd7, 3'b011, 3'b011, 1, 8'd42,  8'd42,  10'h000};
    vecs[5]  = '{1'b0, 3'd7, 3'b011, 3'b011, 4, 8'd126, 8'd126, 10'h000};
    vecs[6]  = '{1'b0, 3'd7, 3'b011, 3'b011, 1, 8'd127, 8'd127, 10'h3FF};
    vecs[7]  = '{1'b0, 3'd7, 3'b011, 3'b011, 3, 8'd127, 8'd127, 10'h3FF};
    // -28 per edge: -112 after 4, -140 clamps to -128 on the 5th.
    vecs[8]  = '{1'b1, 3'd7, 3'b100, 3'b100, 4, 8'h90, 8'h90, 10'h000};
    vecs[9]  = '{1'b0, 3'd7, 3'b100, 3'b100, 1, 8'h80, 8'h80, 10'h3FF};
    vecs[10] = '{1'b0, 3'd7, 3'b100, 3'b100, 2, 8'h80, 8'h80, 10'h3FF};
    // Lane independence: even lanes saturate, odd lanes (w=0) stay at 0.
    vecs[11] = '{1'b1, 3'd7, 3'b011, 3'b000, 8, 8'd127, 8'h00, 10'h155};
    // Coming back off the rail keeps the flag set.
    vecs[12] = '{1'b0, 3'd1, 3'b100, 3'b100, 1, 8'd123, 8'hFC, 10'h155};
    // Zero activation leaves everything unchanged.
    vecs[13] = '{1'b0, 3'd0, 3'b100, 3'b011, 3, 8'd123, 8'hFC, 10'h155};
    // Mixed signs, small values: 5*(-2) = -10, 5*1 = 5.
    vecs[14] = '{1'b1, 3'd5, 3'b110, 3'b001, 1, 8'hF6, 8'h05, 10'h000};
    vecs[15] = '{1'b0, 3'd3, 3'b110, 3'b001, 2, 8'hEA, 8'h0B, 10'h000};

    bus.layer2In  = '0;
    bus.weightsIn = '0;
    clr = 1'b1;
    #1;
    exp_q.push_back('0);
    check_sum("reset_sum");
    check_sat("reset_sat", '0);

    for (int i = 0; i < NV; i++) begin
      if (vecs[i].do_rst) do_reset();
      bus.layer2In  = vecs[i].in_val;
      bus.weightsIn = pack_w(vecs[i].w_even, vecs[i].w_odd);
      run_edges(vecs[i].edges);
      exp_q.push_back(pack_s(vecs[i].exp_even, vecs[i].exp_odd));
      check_sum($sformatf("vec%0d", i));
      check_sat($sformatf("vec%0d", i), vecs[i].exp_sat);
    end

    // Asynchronous clear between edges: sums are nonzero (-22 / 11) here.
    #2;
    clr = 1'b1;
    #1;
    exp_q.push_back('0);
    check_sum("async_clr_sum");
    check_sat("async_clr_sat", '0);

    // Held in clear across an edge with nonzero inputs: nothing accumulates.
    bus.layer2In  = 3'd7;
    bus.weightsIn = pack_w(3'b011, 3'b011);
    @(posedge clk);
    #1;
    exp_q.push_back('0);
    check_sum("clr_held_sum");
    check_sat("clr_held_sat", '0);

    // Release and confirm accumulation restarts from zero.
    @(negedge clk);
    clr = 1'b0;
    bus.layer2In  = 3'd1;
    bus.weightsIn = pack_w(3'b111, 3'b011);
    run_edges(1);
    exp_q.push_back(pack_s(8'hFF, 8'h03));
    check_sum("restart_sum");
    check_sat("restart_sat", '0);

    // ---------------- final report ----------------
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
